// File: rtl/weight_addr_gen.sv
// weight_addr_gen: sweeps a row-major {row,col} address space over one tile
// for the systolic array delay chain. After the last address it holds
// enable/cs low for DRAIN_CYCLES so that every delayed copy downstream has
// flushed, and then pulses done for one cycle.
//
// Handshake: address_out is valid in any cycle where enable_out=1. pause is a
// registered backpressure input. A pause sampled on an edge suppresses the
// issue in the cycle that follows that edge. An address that has already been
// issued is never repeated. pause on the edge that closes the last issue is a
// no-op, because the sweep is finishing anyway.
module weight_addr_gen #(
    parameter int FEATURE_BITS = 4,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                      sys_clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [FEATURE_BITS-1:0]   n_rows,
    input  logic [FEATURE_BITS-1:0]   n_cols,
    input  logic                      pause,
    output logic [2*FEATURE_BITS-1:0] address_out,
    output logic                      enable_out,
    output logic                      cs_out,
    output logic                      busy,
    output logic                      done
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [FEATURE_BITS-1:0] row_q, row_d;
    logic [FEATURE_BITS-1:0] col_q, col_d;
    logic [FEATURE_BITS-1:0] n_rows_q, n_rows_d;
    logic [FEATURE_BITS-1:0] n_cols_q, n_cols_d;
    logic                    en_q, en_d;
    logic                    cs_q, cs_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    last_addr;

    // The address currently on the bus is the final one of the tile.
    assign last_addr = (row_q == n_rows_q) && (col_q == n_cols_q);

    // Next-state and registered-output computation for the sweep sequencer.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        n_rows_d = n_rows_q;
        n_cols_d = n_cols_q;
        en_d     = 1'b0;
        cs_d     = cs_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                cs_d   = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    n_rows_d = n_rows;
                    n_cols_d = n_cols;
                    row_d    = '0;
                    col_d    = '0;
                    cs_d     = 1'b1;
                    busy_d   = 1'b1;
                    en_d     = ~pause;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (en_q && last_addr) begin
                    // Last address was issued this cycle: stop and flush.
                    cs_d    = 1'b0;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                    state_d = S_DRAIN;
                end else begin
                    en_d = ~pause;
                    if (en_q) begin
                        if (col_q == n_cols_q) begin
                            col_d = '0;
                            row_d = row_q + FEATURE_BITS'(1);
                        end else begin
                            col_d = col_q + FEATURE_BITS'(1);
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers. An asynchronous reset aborts any sweep.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            n_rows_q <= '0;
            n_cols_q <= '0;
            en_q     <= 1'b0;
            cs_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            n_rows_q <= n_rows_d;
            n_cols_q <= n_cols_d;
            en_q     <= en_d;
            cs_q     <= cs_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    assign address_out = {row_q, col_q};
    assign enable_out  = en_q;
    assign cs_out      = cs_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_weight_addr_gen.sv
// Bench for weight_addr_gen: the expected address stream is queued when a
// sweep starts and popped on every enable cycle. Drain and done timing is
// checked against the fixed drain depth.
module tb_weight_addr_gen;

    localparam int FB    = 4;
    localparam int DRAIN = 4;

    logic          sys_clk;
    logic          reset_n;
    logic          start;
    logic [FB-1:0] n_rows;
    logic [FB-1:0] n_cols;
    logic          pause;
    logic [7:0]    address_out;
    logic          enable_out;
    logic          cs_out;
    logic          busy;
    logic          done;

    logic [7:0] exp_q[$];
    int         n_vec;
    int         n_err;

    weight_addr_gen #(.FEATURE_BITS(FB), .DRAIN_CYCLES(DRAIN)) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .start       (start),
        .n_rows      (n_rows),
        .n_cols      (n_cols),
        .pause       (pause),
        .address_out (address_out),
        .enable_out  (enable_out),
        .cs_out      (cs_out),
        .busy        (busy),
        .done        (done)
    );

    // clock / reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One full sweep. Inputs are driven and outputs sampled on the falling edge.
    // pause_at: after the issue with this 1-based index, pause is held for
    // pause_len edges (0 = no pause).
    task automatic run_sweep(input int nr, input int nc, input int pause_at,
                             input int pause_len, input bit poke_mid, input bit poke_done);
        int   total;
        int   issued;
        int   gaps;
        int   pause_left;
        int   cyc;
        int   exp_gaps;
        logic [7:0] e;
        total      = (nr + 1) * (nc + 1);
        issued     = 0;
        gaps       = 0;
        pause_left = 0;
        cyc        = 0;
        exp_gaps   = (pause_at > 0 && pause_at < total) ? pause_len : 0;
        for (int r = 0; r <= nr; r++)
            for (int c = 0; c <= nc; c++)
                exp_q.push_back({4'(r), 4'(c)});

        @(negedge sys_clk);
        start  = 1'b1;
        n_rows = 4'(nr);
        n_cols = 4'(nc);
        pause  = 1'b0;
        @(negedge sys_clk);
        start = 1'b0;
        while (cyc < 1000) begin
            if (enable_out) begin
                check("cs_on_issue", 32'(cs_out), 32'd1);
                check("busy_on_issue", 32'(busy), 32'd1);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                check("addr", 32'(address_out), 32'(e));
                issued++;
            end else begin
                check("cs_in_gap", 32'(cs_out), 32'd1);
                gaps++;
            end
            start = 1'b0;
            if (poke_mid && enable_out && issued == 2) begin
                start  = 1'b1;
                n_rows = 4'd3;
            end
            if (enable_out && issued == pause_at) pause_left = pause_len;
            pause = (pause_left > 0);
            if (pause_left > 0) pause_left--;
            if (issued == total) break;
            @(negedge sys_clk);
            cyc++;
        end
        if (cyc >= 1000) begin
            check("sweep_timeout", 32'd1, 32'd0);
            return;
        end
        check("gap_count", 32'(gaps), 32'(exp_gaps));
        for (int d = 1; d <= DRAIN; d++) begin
            @(negedge sys_clk);
            start = 1'b0;
            pause = 1'b0;
            check("drain_en", 32'(enable_out), 32'd0);
            check("drain_cs", 32'(cs_out), 32'd0);
            check("drain_busy", 32'(busy), 32'd1);
            check("drain_done", 32'(done), 32'd0);
        end
        @(negedge sys_clk);
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        if (poke_done) start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        check("post_done", 32'(done), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_cs", 32'(cs_out), 32'd0);
        check("post_en", 32'(enable_out), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // An asynchronous reset mid-RUN, driven away from the clock edge.
    task automatic reset_mid_run();
        @(negedge sys_clk);
        start  = 1'b1;
        n_rows = 4'd1;
        n_cols = 4'd2;
        pause  = 1'b0;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        @(posedge sys_clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_addr", 32'(address_out), 32'd0);
        check("rst_en", 32'(enable_out), 32'd0);
        check("rst_cs", 32'(cs_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge sys_clk);
        check("rst_hold_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        repeat (DRAIN + 3) begin
            @(negedge sys_clk);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end
    endtask

    initial begin
        int nr;
        int nc;
        int tot;
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        n_rows  = '0;
        n_cols  = '0;
        pause   = 1'b0;
        #17;
        check("reset_addr", 32'(address_out), 32'd0);
        check("reset_en", 32'(enable_out), 32'd0);
        check("reset_cs", 32'(cs_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(negedge sys_clk);
        reset_n = 1'b1;
        @(negedge sys_clk);

        run_sweep(1, 2, 0, 0, 1'b0, 1'b0);      // basic sweep
        run_sweep(1, 2, 2, 2, 1'b0, 1'b0);      // pause after 0x01
        run_sweep(15, 15, 0, 0, 1'b0, 1'b0);    // full range
        run_sweep(0, 0, 0, 0, 1'b0, 1'b0);      // degenerate tile
        run_sweep(1, 2, 6, 2, 1'b0, 1'b0);      // pause as 0x12 is issued
        run_sweep(1, 2, 0, 0, 1'b1, 1'b1);      // mid-run start, start held in done
        run_sweep(1, 2, 0, 0, 1'b0, 1'b0);      // new sweep from IDLE
        for (int k = 0; k < 3; k++) begin
            nr  = $urandom_range(0, 5);
            nc  = $urandom_range(0, 5);
            tot = (nr + 1) * (nc + 1);
            run_sweep(nr, nc, $urandom_range(1, tot), $urandom_range(1, 3), 1'b0, 1'b0);
        end
        reset_mid_run();
        run_sweep(1, 2, 0, 0, 1'b0, 1'b0);      // fresh start after reset

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the sequence stalls somewhere outside a bounded loop.
    initial begin
        #200000;
        $display("FAIL global_timeout: got stall expected completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
